// File: rtl/tlc_light_monitor.sv
// Passive traffic-light bus checker: conflict, dark, illegal transition, short amber and stall detection with first-fault latch.
// Latency: one cycle from a sampled pattern to every output. No backpressure; it only observes. Optional fault_cnt via TLC_MON_FAULT_CNT_EN.
module tlc_light_monitor #(
    parameter int AMBER_MIN = 4,
    parameter int MAX_DWELL = 31,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       light_in,
    input  logic             light_valid,
    input  logic             fault_clr,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       fault_appr,
    output logic             phase_chg,
    output logic             all_red,
    output logic [CNT_W-1:0] dwell
`ifdef TLC_MON_FAULT_CNT_EN
    ,
    output logic [7:0]       fault_cnt
`endif
);

    typedef enum logic [1:0] {
        LAMP_DARK  = 2'b00,
        LAMP_RED   = 2'b01,
        LAMP_AMBER = 2'b10,
        LAMP_GREEN = 2'b11
    } lamp_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] AMB_MIN_C = CNT_W'(AMBER_MIN);
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(MAX_DWELL);

    logic [7:0]       prev_q;
    logic             prev_valid_q;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] amb_cnt_q [4];
    logic [CNT_W-1:0] amb_cnt_d [4];
    logic             fault_q;
    logic [2:0]       fault_code_q;
    logic [1:0]       fault_appr_q;
    logic             phase_chg_q;
    logic             all_red_q;
    logic [2:0]       chk_code;
    logic [1:0]       chk_appr;
    logic             chk_fire;
    logic             dark_any, ill_any, sa_any;
    logic [1:0]       dark_idx, ill_idx, sa_idx;
    lamp_e            cur, prv;

    always_comb begin
        dark_any = 1'b0;
        ill_any  = 1'b0;
        sa_any   = 1'b0;
        dark_idx = 2'd0;
        ill_idx  = 2'd0;
        sa_idx   = 2'd0;
        cur      = LAMP_DARK;
        prv      = LAMP_DARK;
        // Scan from W down to N so the lowest-index offender is written last.
        for (int i = 3; i >= 0; i--) begin
            cur = lamp_e'(light_in[7-2*i -: 2]);
            prv = lamp_e'(prev_q[7-2*i -: 2]);
            if (cur == LAMP_DARK) begin
                dark_any = 1'b1;
                dark_idx = 2'(i);
            end
            if (prev_valid_q && cur != prv &&
                !((prv == LAMP_RED   && cur == LAMP_GREEN) ||
                  (prv == LAMP_GREEN && cur == LAMP_AMBER) ||
                  (prv == LAMP_AMBER && cur == LAMP_RED))) begin
                ill_any = 1'b1;
                ill_idx = 2'(i);
            end
            if (prev_valid_q && prv == LAMP_AMBER && cur == LAMP_RED &&
                amb_cnt_q[i] < AMB_MIN_C) begin
                sa_any = 1'b1;
                sa_idx = 2'(i);
            end
            if (cur == LAMP_AMBER) begin
                amb_cnt_d[i] = (amb_cnt_q[i] == CNT_MAX) ? CNT_MAX : amb_cnt_q[i] + 1'b1;
            end else begin
                amb_cnt_d[i] = '0;
            end
        end

        if (!prev_valid_q || light_in != prev_q) begin
            dwell_d = CNT_W'(1);
        end else if (dwell_q == CNT_MAX) begin
            dwell_d = CNT_MAX;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end

        chk_code = 3'd0;
        chk_appr = 2'd0;
        // Amber and green both have bit 1 set; red and dark do not.
        if ((light_in[7] | light_in[3]) && (light_in[5] | light_in[1])) begin
            chk_code = 3'd1;
        end else if (dark_any) begin
            chk_code = 3'd2;
            chk_appr = dark_idx;
        end else if (ill_any) begin
            chk_code = 3'd3;
            chk_appr = ill_idx;
        end else if (sa_any) begin
            chk_code = 3'd4;
            chk_appr = sa_idx;
        end else if (dwell_d > DWELL_MAX) begin
            chk_code = 3'd5;
        end
        chk_fire = (chk_code != 3'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            dwell_q      <= '0;
            amb_cnt_q    <= '{default: '0};
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
            fault_appr_q <= 2'd0;
            phase_chg_q  <= 1'b0;
            all_red_q    <= 1'b0;
        end else if (light_valid) begin
            prev_q       <= light_in;
            prev_valid_q <= 1'b1;
            dwell_q      <= dwell_d;
            amb_cnt_q    <= amb_cnt_d;
            phase_chg_q  <= prev_valid_q && (light_in != prev_q);
            all_red_q    <= (light_in == 8'b0101_0101);
            // A fresh fault on a clear cycle takes precedence over the clear.
            if (chk_fire && (!fault_q || fault_clr)) begin
                fault_q      <= 1'b1;
                fault_code_q <= chk_code;
                fault_appr_q <= chk_appr;
            end else if (fault_clr) begin
                fault_q      <= 1'b0;
                fault_code_q <= 3'd0;
                fault_appr_q <= 2'd0;
            end
        end else begin
            phase_chg_q <= 1'b0;
            if (fault_clr) begin
                fault_q      <= 1'b0;
                fault_code_q <= 3'd0;
                fault_appr_q <= 2'd0;
            end
        end
    end

`ifdef TLC_MON_FAULT_CNT_EN
    logic [7:0] fault_cnt_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_cnt_q <= 8'd0;
        end else if (light_valid && chk_fire && fault_cnt_q != 8'hFF) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end
    end
    assign fault_cnt = fault_cnt_q;
`endif

    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign fault_appr = fault_appr_q;
    assign phase_chg  = phase_chg_q;
    assign all_red    = all_red_q;
    assign dwell      = dwell_q;

endmodule

// File: tb/tb_tlc_light_monitor.sv
// Scoreboard bench for tlc_light_monitor: directed scenarios then randomized patterns against a lamp-level reference model.
module tb_tlc_light_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] light_in = 8'h00;
    logic       light_valid = 1'b0;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_appr;
    logic       phase_chg;
    logic       all_red;
    logic [5:0] dwell;
`ifdef TLC_MON_FAULT_CNT_EN
    logic [7:0] fault_cnt;
`endif

    tlc_light_monitor #(.AMBER_MIN(4), .MAX_DWELL(31), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .light_in(light_in), .light_valid(light_valid),
        .fault_clr(fault_clr), .fault(fault), .fault_code(fault_code),
        .fault_appr(fault_appr), .phase_chg(phase_chg), .all_red(all_red),
`ifdef TLC_MON_FAULT_CNT_EN
        .fault_cnt(fault_cnt),
`endif
        .dwell(dwell)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f, code, appr, pc, ar, dw, fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: lamps as integers 0 dark, 1 red, 2 amber, 3 green.
    int m_fault, m_code, m_appr, m_pc, m_ar, m_dw, m_fc, m_pv;
    int m_prev[4];
    int m_amb[4];

    function automatic bit legal_step(int p, int c);
        return (p == c) || (p == 1 && c == 3) || (p == 3 && c == 2) || (p == 2 && c == 1);
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit c);
        int lamp[4];
        int code, appr, ndw;
        bit diff;
        if (r) begin
            m_fault = 0; m_code = 0; m_appr = 0; m_pc = 0; m_ar = 0; m_dw = 0; m_fc = 0; m_pv = 0;
            for (int i = 0; i < 4; i++) begin m_prev[i] = 0; m_amb[i] = 0; end
            return;
        end
        if (!v) begin
            m_pc = 0;
            if (c) begin m_fault = 0; m_code = 0; m_appr = 0; end
            return;
        end
        code = 0; appr = 0; diff = 0;
        for (int i = 0; i < 4; i++) begin
            lamp[i] = (int'(d) >> (6 - 2*i)) & 3;
            if (m_pv != 0 && lamp[i] != m_prev[i]) diff = 1;
        end
        if ((lamp[0] >= 2 || lamp[2] >= 2) && (lamp[1] >= 2 || lamp[3] >= 2)) code = 1;
        for (int i = 0; i < 4; i++)
            if (code == 0 && lamp[i] == 0) begin code = 2; appr = i; end
        for (int i = 0; i < 4; i++)
            if (code == 0 && m_pv != 0 && !legal_step(m_prev[i], lamp[i])) begin code = 3; appr = i; end
        for (int i = 0; i < 4; i++)
            if (code == 0 && m_pv != 0 && m_prev[i] == 2 && lamp[i] == 1 && m_amb[i] < 4) begin
                code = 4; appr = i;
            end
        ndw = (m_pv == 0 || diff) ? 1 : ((m_dw < 63) ? m_dw + 1 : 63);
        if (code == 0 && ndw > 31) code = 5;
        for (int i = 0; i < 4; i++) begin
            m_amb[i]  = (lamp[i] == 2) ? ((m_amb[i] < 63) ? m_amb[i] + 1 : 63) : 0;
            m_prev[i] = lamp[i];
        end
        m_pc = diff ? 1 : 0;
        m_ar = (d == 8'h55) ? 1 : 0;
        m_dw = ndw;
        m_pv = 1;
        if (code != 0 && (m_fault == 0 || c)) begin
            m_fault = 1; m_code = code; m_appr = appr;
        end else if (c) begin
            m_fault = 0; m_code = 0; m_appr = 0;
        end
        if (code != 0 && m_fc < 255) m_fc++;
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit c);
        exp_t e;
        @(posedge clk);
        #2;
        reset = r; light_valid = v; light_in = d; fault_clr = c;
        model_step(r, v, d, c);
        e.f = m_fault; e.code = m_code; e.appr = m_appr; e.pc = m_pc;
        e.ar = m_ar; e.dw = m_dw; e.fc = m_fc;
        exp_q.push_back(e);
    endtask

    task automatic smp(input logic [7:0] d);
        drive(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fault", int'(fault), e.f);
                chk("fault_code", int'(fault_code), e.code);
                chk("fault_appr", int'(fault_appr), e.appr);
                chk("phase_chg", int'(phase_chg), e.pc);
                chk("all_red", int'(all_red), e.ar);
                chk("dwell", int'(dwell), e.dw);
`ifdef TLC_MON_FAULT_CNT_EN
                chk("fault_cnt", int'(fault_cnt), e.fc);
`endif
            end
        end
    end

    initial begin : stimulus
        logic [7:0] pool [10] = '{8'h55, 8'hD5, 8'h95, 8'h5D, 8'h59, 8'hDD, 8'h99, 8'h77, 8'h66, 8'hF5};
        logic [7:0] last;
        int wait_cyc;

        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        // Legal cycle: all red, N/S green, N/S amber, all red.
        smp(8'h55);
        repeat (8) smp(8'hDD);
        repeat (4) smp(8'h99);
        smp(8'h55);
        smp(8'hF5);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        smp(8'h55);
        smp(8'h95);
        smp(8'h15);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        smp(8'h55);
        smp(8'hD5);
        smp(8'h95);
        smp(8'h95);
        smp(8'h55);
        drive(1'b0, 1'b0, 8'h55, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (66) smp(8'h55);
        drive(1'b0, 1'b1, 8'h45, 1'b1);
        smp(8'h55);
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        last = 8'h55;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] d;
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 30) d = last;
            else if (sel < 90) d = pool[$urandom_range(0, 9)];
            else d = 8'($urandom);
            last = d;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85, d,
                  $urandom_range(0, 99) < 4);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
